// File: rtl/sqrt_result_bcd_display_pkg.sv
// Shared definitions for the square-root result BCD display block:
// converter state encoding, 7-segment glyph table and parameter legality check.
package sqrt_result_bcd_display_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CONV   = 2'd1,
        COMMIT = 2'd2
    } state_t;

    // Active-high segment patterns, bit order gfedcba, for decimal digits 0..9.
    localparam logic [6:0] SEG7_GLYPH [10] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
        7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F
    };

    // Glyph lookup; non-decimal nibbles render dark.
    function automatic logic [6:0] seg7_glyph(input logic [3:0] nib);
        if (nib <= 4'd9) return SEG7_GLYPH[nib];
        return 7'h00;
    endfunction

    // True when DIGITS decimal digits can hold the largest WIDTH-bit value.
    function automatic bit bcd_width_ok(input int width, input int digits);
        longint p10;
        p10 = 1;
        for (int i = 0; i < digits; i++) p10 = p10 * 10;
        return p10 > ((longint'(1) << width) - 1);
    endfunction

endpackage

// File: rtl/sqrt_seg7_decode.sv
// Nibble to 7-segment decoder with a blanking override. Purely combinational.
module sqrt_seg7_decode
    import sqrt_result_bcd_display_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       blank,
    output logic [6:0] seg
);

    // Blank wins over the glyph; non-decimal nibbles are dark via the table.
    always_comb begin
        seg = blank ? 7'h00 : seg7_glyph(nibble);
    end

endmodule

// File: rtl/sqrt_result_bcd_display.sv
// Captures square-root results, converts them serially to packed BCD with
// shift-add-3, and scans the digits onto a multiplexed 7-segment display.
//
// res_valid is a single-cycle strobe with no back-pressure: a strobe while
// idle starts a conversion; a strobe while busy (including the commit cycle)
// parks the value in a one-deep pending slot where the newest value wins.
module sqrt_result_bcd_display
    import sqrt_result_bcd_display_pkg::*;
#(
    parameter  int WIDTH    = 11,
    parameter  int DIGITS   = 4,
    parameter  int DWELL    = 1024,
    parameter  int BLANK_LZ = 1,
    localparam int SEL_W    = (DIGITS > 1) ? $clog2(DIGITS) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  res_valid,
    input  logic [WIDTH-1:0]      res_in,
    output logic                  busy,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic                  bcd_valid,
    output logic [6:0]            seg,
    output logic                  dp,
    output logic [SEL_W-1:0]      digit_sel,
    output state_t                dbg_state
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int SR_W  = BCD_W + WIDTH;
    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam int DW_W  = (DWELL > 1) ? $clog2(DWELL) : 1;

    if (!bcd_width_ok(WIDTH, DIGITS)) begin : g_bad_digits
        $error("DIGITS too small to represent every WIDTH-bit value");
    end
    if (DWELL < 1) begin : g_bad_dwell
        $error("DWELL must be at least 1");
    end

    state_t              state;
    logic [SR_W-1:0]     sr;
    logic [SR_W-1:0]     sr_adj;
    logic [SR_W-1:0]     sr_next;
    logic [CNT_W-1:0]    bit_cnt;
    logic                pend;
    logic [WIDTH-1:0]    pend_val;
    logic [DW_W-1:0]     dwell_cnt;
    logic [DIGITS-1:0]   blank_vec;
    logic [3:0]          sel_nib;
    logic                sel_blank;

    assign dbg_state = state;

    // One double-dabble step: correct every BCD nibble >= 5, then shift left.
    always_comb begin
        sr_adj = sr;
        for (int i = 0; i < DIGITS; i++) begin
            if (sr_adj[WIDTH+4*i +: 4] >= 4'd5)
                sr_adj[WIDTH+4*i +: 4] = sr_adj[WIDTH+4*i +: 4] + 4'd3;
        end
        sr_next = {sr_adj[SR_W-2:0], 1'b0};
    end

    // Conversion FSM with pending-slot capture and result commit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            busy      <= 1'b0;
            bcd_out   <= '0;
            bcd_valid <= 1'b0;
            pend      <= 1'b0;
            pend_val  <= '0;
            sr        <= '0;
            bit_cnt   <= '0;
        end else begin
            bcd_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (res_valid) begin
                        sr      <= {{BCD_W{1'b0}}, res_in};
                        bit_cnt <= CNT_W'(WIDTH);
                        busy    <= 1'b1;
                        state   <= CONV;
                    end
                end
                CONV: begin
                    sr      <= sr_next;
                    bit_cnt <= bit_cnt - 1'b1;
                    if (bit_cnt == CNT_W'(1)) state <= COMMIT;
                    if (res_valid) begin
                        pend     <= 1'b1;
                        pend_val <= res_in;
                    end
                end
                COMMIT: begin
                    bcd_out   <= sr[SR_W-1:WIDTH];
                    bcd_valid <= 1'b1;
                    // A strobe landing on this edge is newer than the pending slot.
                    if (res_valid || pend) begin
                        sr      <= {{BCD_W{1'b0}}, (res_valid ? res_in : pend_val)};
                        bit_cnt <= CNT_W'(WIDTH);
                        pend    <= 1'b0;
                        busy    <= 1'b1;
                        state   <= CONV;
                    end else begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Free-running scan: hold each digit DWELL cycles, MSD down to LSD.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dwell_cnt <= '0;
            digit_sel <= SEL_W'(DIGITS - 1);
        end else if (dwell_cnt == DW_W'(DWELL - 1)) begin
            dwell_cnt <= '0;
            digit_sel <= (digit_sel == '0) ? SEL_W'(DIGITS - 1) : digit_sel - 1'b1;
        end else begin
            dwell_cnt <= dwell_cnt + 1'b1;
        end
    end

    // Leading-zero mask: a digit blanks when it and all digits above are zero.
    always_comb begin
        logic zero_run;
        zero_run  = 1'b1;
        blank_vec = '0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            zero_run     = zero_run && (bcd_out[4*i +: 4] == 4'd0);
            blank_vec[i] = (BLANK_LZ != 0) && zero_run && (i != 0);
        end
    end

    // Select the nibble and blank flag for the digit currently scanned.
    always_comb begin
        sel_nib   = 4'd0;
        sel_blank = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (digit_sel == SEL_W'(i)) begin
                sel_nib   = bcd_out[4*i +: 4];
                sel_blank = blank_vec[i];
            end
        end
    end

    assign dp = (digit_sel == '0);

    sqrt_seg7_decode u_decode (
        .nibble (sel_nib),
        .blank  (sel_blank),
        .seg    (seg)
    );

endmodule

// File: tb/tb_sqrt_result_bcd_display.sv
// Bench for sqrt_result_bcd_display: table-driven vectors, directed
// multi-cycle sequences, and randomized values checked against a decimal model.
module tb_sqrt_result_bcd_display;
    import sqrt_result_bcd_display_pkg::*;

    localparam int W  = 11;
    localparam int D  = 4;
    localparam int DW = 4;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic          res_valid = 1'b0;
    logic [W-1:0]  res_in    = '0;

    logic          busy, bcd_valid, dp;
    logic [15:0]   bcd_out;
    logic [6:0]    seg;
    logic [1:0]    digit_sel;
    state_t        dbg_state;

    logic          b_busy, b_bcd_valid, b_dp;
    logic [15:0]   b_bcd_out;
    logic [6:0]    b_seg;
    logic [1:0]    b_digit_sel;
    state_t        b_dbg_state;

    sqrt_result_bcd_display #(.WIDTH(W), .DIGITS(D), .DWELL(DW), .BLANK_LZ(1)) dut (
        .clk(clk), .rst(rst), .res_valid(res_valid), .res_in(res_in),
        .busy(busy), .bcd_out(bcd_out), .bcd_valid(bcd_valid), .seg(seg),
        .dp(dp), .digit_sel(digit_sel), .dbg_state(dbg_state)
    );

    sqrt_result_bcd_display #(.WIDTH(W), .DIGITS(D), .DWELL(DW), .BLANK_LZ(0)) dut_nb (
        .clk(clk), .rst(rst), .res_valid(res_valid), .res_in(res_in),
        .busy(b_busy), .bcd_out(b_bcd_out), .bcd_valid(b_bcd_valid), .seg(b_seg),
        .dp(b_dp), .digit_sel(b_digit_sel), .dbg_state(b_dbg_state)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int pow10(input int d);
        int p = 1;
        for (int i = 0; i < d; i++) p = p * 10;
        return p;
    endfunction

    function automatic int digit_of(input int v, input int d);
        return (v / pow10(d)) % 10;
    endfunction

    function automatic logic [15:0] to_bcd(input int v);
        logic [15:0] r = '0;
        for (int d = 0; d < D; d++) r[4*d +: 4] = 4'(digit_of(v, d));
        return r;
    endfunction

    function automatic logic [6:0] glyph(input int n);
        case (n)
            0: return 7'h3F;  1: return 7'h06;  2: return 7'h5B;  3: return 7'h4F;
            4: return 7'h66;  5: return 7'h6D;  6: return 7'h7D;  7: return 7'h07;
            8: return 7'h7F;  9: return 7'h6F;
            default: return 7'h00;
        endcase
    endfunction

    // Digit d is a leading zero exactly when the value is below 10^d.
    function automatic logic [6:0] exp_seg(input int v, input int d, input bit blz);
        if (blz && d != 0 && v < pow10(d)) return 7'h00;
        return glyph(digit_of(v, d));
    endfunction

    // ---------------- scoreboard / monitor ----------------
    int exp_q[$];
    int disp_val = 0;
    int cyc = 0;

    always @(posedge clk or posedge rst) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    always @(negedge clk) begin
        int es, v;
        if (!rst) begin
            if (bcd_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_bcd_valid", 1, 0);
                end else begin
                    v = exp_q.pop_front();
                    check("commit_bcd", bcd_out, to_bcd(v));
                    check("commit_bcd_nb", b_bcd_out, to_bcd(v));
                    disp_val = v;
                end
            end
            es = D - 1 - ((cyc / DW) % D);
            check("scan_sel", digit_sel, es);
            check("scan_dp", dp, (es == 0));
            check("scan_seg", seg, exp_seg(disp_val, es, 1'b1));
            check("scan_seg_nb", b_seg, exp_seg(disp_val, es, 1'b0));
        end
    end

    // ---------------- driver tasks ----------------
    // Called just after a negedge; returns at the negedge after the capture edge.
    task automatic strobe(input int v);
        res_in    = W'(v);
        res_valid = 1'b1;
        @(negedge clk);
        res_valid = 1'b0;
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (n < 40) begin
            @(negedge clk);
            n++;
            if (bcd_valid) return;
        end
        n = -1;
    endtask

    typedef struct {
        int          val;
        logic [15:0] bcd;
        logic [27:0] segs;     // {d3, d2, d1, d0}, leading zeros blanked
        logic [27:0] segs_nb;  // {d3, d2, d1, d0}, no blanking
    } vec_t;

    vec_t vecs [7];

    initial begin : watchdog
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int n, n1, n2;
        logic [6:0] cap [4];
        logic [6:0] cap_nb [4];

        vecs[0] = '{45,   16'h0045, {7'h00, 7'h00, 7'h66, 7'h6D}, {7'h3F, 7'h3F, 7'h66, 7'h6D}};
        vecs[1] = '{2047, 16'h2047, {7'h5B, 7'h3F, 7'h66, 7'h07}, {7'h5B, 7'h3F, 7'h66, 7'h07}};
        vecs[2] = '{0,    16'h0000, {7'h00, 7'h00, 7'h00, 7'h3F}, {7'h3F, 7'h3F, 7'h3F, 7'h3F}};
        vecs[3] = '{999,  16'h0999, {7'h00, 7'h6F, 7'h6F, 7'h6F}, {7'h3F, 7'h6F, 7'h6F, 7'h6F}};
        vecs[4] = '{1000, 16'h1000, {7'h06, 7'h3F, 7'h3F, 7'h3F}, {7'h06, 7'h3F, 7'h3F, 7'h3F}};
        vecs[5] = '{1805, 16'h1805, {7'h06, 7'h7F, 7'h3F, 7'h6D}, {7'h06, 7'h7F, 7'h3F, 7'h6D}};
        vecs[6] = '{60,   16'h0060, {7'h00, 7'h00, 7'h7D, 7'h3F}, {7'h3F, 7'h3F, 7'h7D, 7'h3F}};

        // Reset values
        #1 rst = 1'b1;
        #2;
        check("rst_busy", busy, 0);
        check("rst_bcd", bcd_out, 0);
        check("rst_bcd_valid", bcd_valid, 0);
        check("rst_sel", digit_sel, 3);
        check("rst_seg_blank", seg, 7'h00);
        check("rst_seg_nb", b_seg, 7'h3F);
        check("rst_dp", dp, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        // Table-driven vectors: latency, value and one full scan frame
        for (int k = 0; k < 7; k++) begin
            exp_q.push_back(vecs[k].val);
            strobe(vecs[k].val);
            check("busy_after_capture", busy, 1);
            wait_valid(n);
            check("latency", n, 12);
            check("vec_bcd", bcd_out, vecs[k].bcd);
            for (int c = 0; c < 4 * DW; c++) begin
                @(negedge clk);
                cap[digit_sel]    = seg;
                cap_nb[digit_sel] = b_seg;
            end
            for (int d = 0; d < 4; d++) begin
                check("vec_seg", cap[d], vecs[k].segs[7*d +: 7]);
                check("vec_seg_nb", cap_nb[d], vecs[k].segs_nb[7*d +: 7]);
            end
            check("idle_busy", busy, 0);
        end

        // Overlapping strobes: 100, then 9 at +3 and 30 at +5; 9 is overwritten
        exp_q.push_back(100);
        exp_q.push_back(30);
        strobe(100);
        repeat (2) @(negedge clk);
        strobe(9);
        @(negedge clk);
        strobe(30);
        n1 = -1;
        n2 = -1;
        for (int c = 6; c <= 30; c++) begin
            @(negedge clk);
            if (c < 24) check("pend_busy", busy, 1);
            if (bcd_valid && n1 < 0) n1 = c;
            else if (bcd_valid && n2 < 0) n2 = c;
        end
        check("pend_first_at", n1, 12);
        check("pend_second_at", n2, 24);
        check("pend_final_bcd", bcd_out, 16'h0030);
        check("pend_idle_busy", busy, 0);

        // Strobe landing on the commit edge is taken immediately
        exp_q.push_back(7);
        exp_q.push_back(8);
        strobe(7);
        repeat (11) @(negedge clk);
        strobe(8);
        check("commit_edge_valid", bcd_valid, 1);
        check("commit_edge_busy", busy, 1);
        wait_valid(n);
        check("commit_edge_latency", n, 12);
        check("commit_edge_bcd", bcd_out, 16'h0008);
        repeat (2) @(negedge clk);

        // Reset in the middle of a conversion discards it
        strobe(1234);
        repeat (5) @(negedge clk);
        #1 rst = 1'b1;
        disp_val = 0;
        #1;
        check("midrst_busy", busy, 0);
        check("midrst_bcd", bcd_out, 0);
        check("midrst_valid", bcd_valid, 0);
        check("midrst_sel", digit_sel, 3);
        check("midrst_seg", seg, 7'h00);
        @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        check("midrst_bcd_after", bcd_out, 0);
        check("midrst_idle", busy, 0);

        // Randomized values against the decimal model
        for (int k = 0; k < 25; k++) begin
            int v;
            v = int'($urandom_range(0, 2047));
            exp_q.push_back(v);
            strobe(v);
            wait_valid(n);
            check("rand_latency", n, 12);
            repeat ($urandom_range(0, 9)) @(negedge clk);
        end

        repeat (4) @(negedge clk);
        check("queue_drained", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sqrt_result_bcd_display.md
Name: sqrt_result_bcd_display

Overview:
- Downstream consumer of the iterative square-root core.
- Captures each completed root on a one-cycle strobe, converts it serially from binary to packed BCD by shift-add-3 (double-dabble), and drives a time-multiplexed 7-segment display, one digit at a time.
- Sits between the root core's result register and the chip output pins. Also exposes the packed BCD word and a completion strobe for other consumers.

Parameters:
- WIDTH, 11, bit width of the binary input value.
- DIGITS, 4, number of BCD digits. Must satisfy 10^DIGITS > 2^WIDTH-1.
- DWELL, 1024, clock cycles each digit is shown before the scan advances. Must be at least 1.
- BLANK_LZ, 1, when 1, leading zero digits are blanked. The least significant digit is never blanked.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- res_valid  in  1  one-cycle strobe: res_in holds a new result.
- res_in  in  WIDTH  binary root value.
- busy  out  1  conversion in progress.
- bcd_out  out  4*DIGITS  packed BCD of the last committed value; digit 0 (units) is in bits [3:0].
- bcd_valid  out  1  one-cycle strobe on the cycle bcd_out updates.
- seg  out  7  active-high segments; seg[0]=a through seg[6]=g.
- dp  out  1  decimal point; high while digit 0 is selected (frame marker).
- digit_sel  out  clog2(DIGITS)  index of the digit currently on seg.

Behaviour:
- Reset, asynchronous and immediate:
  - state=IDLE, busy=0, bcd_out=0, bcd_valid=0.
  - Pending flag cleared, dwell counter=0, digit_sel=DIGITS-1.
  - seg shows blank if BLANK_LZ=1, else glyph "0".
  - Reset mid-conversion discards the conversion and any pending value.
- States: IDLE, CONV, COMMIT.
- IDLE:
  - When res_valid=1 at edge E0: load the shift register with {BCD=0, bin=res_in}, bit counter=WIDTH, go to CONV, busy=1.
- CONV, per edge:
  - For each BCD nibble >= 5, add 3 to that nibble.
  - Then shift the whole register left by 1 and decrement the bit counter.
  - After the WIDTH-th shift (edge E_WIDTH), go to COMMIT.
- COMMIT (edge E_WIDTH+1):
  - bcd_out <= BCD field and bcd_valid=1 for exactly this cycle.
  - busy=0.
  - If pending=1: load the pending value, clear pending, go to CONV (busy stays 1). Otherwise go to IDLE.
- Latency: bcd_valid asserts WIDTH+1 edges after the capturing edge, which is 12 cycles at defaults.
- res_valid while busy: latch res_in into a one-deep pending register and set pending. A later strobe overwrites it, so the newest value wins and earlier ones are dropped.
- res_valid on the COMMIT edge counts as pending and is serviced immediately.
- Display scan:
  - It is free-running and independent of the conversion FSM.
  - The dwell counter counts 0..DWELL-1. On wrap, digit_sel decrements, wrapping from 0 back to DIGITS-1. Scan order is MSD to LSD.
  - seg is the combinational glyph of the bcd_out nibble selected by digit_sel.
- Display content changes only at COMMIT. The scan position is not reset by a new value.
- Glyphs (gfedcba): 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F.
- Nibbles 10-15 cannot occur; they display as 00.
- Blanking: with BLANK_LZ=1, a digit is blanked (seg=00) if it and every more significant digit are zero, except digit 0. dp is unaffected by blanking.

Decomposition:
- Shared package holds:
  - state encoding (IDLE/CONV/COMMIT, 2 bits);
  - the 7-segment glyph constant table;
  - the WIDTH/DIGITS legality check.
- One sub-module, sqrt_seg7_decode: 4-bit nibble plus blank input to 7-bit seg, purely combinational.
- FSM, converter and scanner live in the top module.

Test Plan:
- Reset, then res_in=45 strobe: bcd_valid exactly 12 cycles later; bcd_out=0x0045. With BLANK_LZ=1, the scan shows blank, blank, 66, 6D with dp high on the last digit.
- res_in=2047: bcd_out=0x2047. Scan shows 5B, 3F, 66, 07 (no blanking applies).
- res_in=0 with BLANK_LZ=1: bcd_out=0x0000. Digits 3..1 blank and digit 0 = 3F. With BLANK_LZ=0, all four digits show 3F.
- Strobe 100; strobe 9 at +3 cycles and 30 at +5 cycles:
  - first bcd_valid gives 0x0100;
  - next bcd_valid follows 12 cycles later with 0x0030;
  - 9 never appears;
  - busy stays high throughout.
- Assert rst at cycle 6 of a conversion of 1234: outputs return immediately to reset values, no bcd_valid follows, and bcd_out stays 0x0000.
- DWELL=4: digit_sel steps 3,2,1,0,3 every 4 cycles; dp is high only when digit_sel=0. A strobe mid-scan does not perturb digit_sel timing.
